// File: rtl/mem_ctl.sv
// -----------------------------------------------------------------------------
// mem_ctl -- CPU-side memory responder driving an asynchronous SRAM.
//
// Accepts one access at a time from the instruction decoder's
// ram_read/ram_write handshake and runs it against the SRAM with a fixed
// number of extra wait states. Writes are posted: mem_busy covers the write
// plus one data-hold cycle, and the CPU only stalls if it issues another
// access in that window. Reads finish with a one-cycle mem_ready pulse and
// rdata holds the value until the next read completes.
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   ram_read    in   read request, sampled only in IDLE
//   ram_write   in   write request, sampled only in IDLE (wins over read)
//   addr        in   request address
//   wdata       in   write data
//   mem_busy    out  access in progress, requests ignored while high
//   mem_ready   out  one-cycle pulse, rdata valid
//   rdata       out  registered read data
//   sram_addr   out  registered SRAM address
//   sram_dout   out  registered SRAM write data
//   sram_dq_oe  out  drive sram_dout onto the DQ bus
//   sram_din    in   SRAM read data
//   sram_ce_n   out  chip enable, active-low
//   sram_oe_n   out  output enable, active-low
//   sram_we_n   out  write enable, active-low
// -----------------------------------------------------------------------------
module mem_ctl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 2     // legal range 0..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_busy,
    output logic              mem_ready,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    // A zero-wait build still needs a one-bit counter to keep the datapath legal.
    localparam int CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDY,
        S_WR,
        S_WREC
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] dout_q,  dout_d;

    // NOTE: state is updated only with non-blocking assignments so every
    // register in this block samples the pre-edge value of every other one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        dout_d  = dout_q;

        unique case (state_q)
            S_IDLE: begin
                // Write has priority; a simultaneous read is dropped and the
                // decoder is expected to hold it until it is accepted.
                if (ram_write) begin
                    addr_d  = addr;
                    dout_d  = wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WR;
                end else if (ram_read) begin
                    addr_d  = addr;
                    cnt_d   = CNT_LOAD;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rdata_d = sram_din;
                    state_d = S_RDY;
                end
            end
            S_RDY: begin
                state_d = S_IDLE;
            end
            S_WR: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_WREC;
                end
            end
            S_WREC: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode from the state register alone, so an asynchronous reset
    // drops them in the same instant the state returns to IDLE.
    assign mem_busy   = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_WREC);
    assign mem_ready  = (state_q == S_RDY);
    assign sram_ce_n  = !mem_busy;
    assign sram_oe_n  = (state_q != S_RD);
    assign sram_we_n  = (state_q != S_WR);
    // WREC keeps DQ driven one cycle past the we_n rising edge for data hold.
    assign sram_dq_oe = (state_q == S_WR) || (state_q == S_WREC);

    assign rdata     = rdata_q;
    assign sram_addr = addr_q;
    assign sram_dout = dout_q;

endmodule

// File: tb/tb_mem_ctl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctl -- self-checking bench for mem_ctl.
//
// Two instances: u_dut (WAIT_STATES=2) carries the directed vectors, the
// multi-cycle corner cases and a randomized run against a transaction-level
// model; u_dut0 (WAIT_STATES=0) covers back-to-back zero-wait reads.
// Each instance sees a behavioural async SRAM whose unwritten locations
// return init_val(addr).
// -----------------------------------------------------------------------------
module tb_mem_ctl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // WAIT_STATES=2 instance
    logic        ram_read = 1'b0, ram_write = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic        mem_busy, mem_ready;
    logic [15:0] rdata, sram_addr, sram_dout, sram_din;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    // WAIT_STATES=0 instance
    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [15:0] addr0 = '0, wdata0 = '0;
    logic        busy0, ready0;
    logic [15:0] rdata0, sram_addr0, sram_dout0, sram_din0;
    logic        dq_oe0, ce_n0, oe_n0, we_n0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_ctl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(W)) u_dut (
        .clk(clk), .rst(rst),
        .ram_read(ram_read), .ram_write(ram_write), .addr(addr), .wdata(wdata),
        .mem_busy(mem_busy), .mem_ready(mem_ready), .rdata(rdata),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dq_oe(sram_dq_oe),
        .sram_din(sram_din), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    mem_ctl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .ram_read(rd0), .ram_write(wr0), .addr(addr0), .wdata(wdata0),
        .mem_busy(busy0), .mem_ready(ready0), .rdata(rdata0),
        .sram_addr(sram_addr0), .sram_dout(sram_dout0), .sram_dq_oe(dq_oe0),
        .sram_din(sram_din0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0),
        .sram_we_n(we_n0)
    );

    // {busy, ready, ce_n, oe_n, we_n, dq_oe}
    logic [5:0] stb, stb0;
    assign stb  = {mem_busy, mem_ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe};
    assign stb0 = {busy0, ready0, ce_n0, oe_n0, we_n0, dq_oe0};

    localparam logic [5:0] STB_IDLE = 6'b001110;
    localparam logic [5:0] STB_RD   = 6'b100010;
    localparam logic [5:0] STB_RDY  = 6'b011110;
    localparam logic [5:0] STB_WR   = 6'b100101;
    localparam logic [5:0] STB_WREC = 6'b100111;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h1234) return 16'hBEEF;
        return (a * 16'd7) ^ 16'h3C5A;
    endfunction

    // ---------------- behavioural SRAM models ----------------
    logic [15:0] sram_mem [65536];
    logic        sram_wr  [65536];

    initial begin
        for (int i = 0; i < 65536; i++) sram_wr[i] = 1'b0;
    end

    function automatic logic [15:0] sram_peek(input logic [15:0] a);
        return sram_wr[a] ? sram_mem[a] : init_val(a);
    endfunction

    assign sram_din  = (!sram_ce_n && !sram_oe_n) ? sram_peek(sram_addr) : 16'hDEAD;
    assign sram_din0 = (!ce_n0 && !oe_n0) ? init_val(sram_addr0) : 16'hDEAD;

    // Strobes are sampled before the DUT's state update at this edge.
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr] = sram_dout;
            sram_wr[sram_addr]  = 1'b1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          exp_busy;      // number of busy cycles
        int          exp_ready;     // cycle of the ready pulse, 0 = none
        int          exp_oe_low;
        int          exp_we_low;
        int          exp_dq_last;   // last cycle with dq_oe high, 0 = never
        logic [15:0] exp_rdata;
        logic [15:0] exp_mem;
    } vec_t;

    // Issues one request for one cycle (caller is 1 time unit after a rising
    // edge) and measures the following 8 cycles.
    task automatic run_vec(input vec_t v, input int idx);
        int busy_n = 0, busy_first = 0, oe_low = 0, we_low = 0;
        int dq_last = 0, rdy_cyc = 0, rdy_n = 0;
        ram_read = v.rd; ram_write = v.wr; addr = v.addr; wdata = v.wdata;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                ram_read = 1'b0; ram_write = 1'b0;
                addr = 16'hFFFF; wdata = 16'h5555;
            end
            if (mem_busy) begin busy_n++; if (busy_first == 0) busy_first = c; end
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (sram_dq_oe) dq_last = c;
            if (mem_ready) begin rdy_n++; if (rdy_cyc == 0) rdy_cyc = c; end
        end
        check($sformatf("vec%0d_busy_cycles", idx), busy_n, v.exp_busy);
        check($sformatf("vec%0d_busy_first", idx), busy_first, 1);
        check($sformatf("vec%0d_ready_cycle", idx), rdy_cyc, v.exp_ready);
        check($sformatf("vec%0d_ready_count", idx), rdy_n, (v.exp_ready != 0) ? 1 : 0);
        check($sformatf("vec%0d_oe_low", idx), oe_low, v.exp_oe_low);
        check($sformatf("vec%0d_we_low", idx), we_low, v.exp_we_low);
        check($sformatf("vec%0d_dq_last", idx), dq_last, v.exp_dq_last);
        check($sformatf("vec%0d_rdata", idx), rdata, v.exp_rdata);
        check($sformatf("vec%0d_mem", idx), sram_peek(v.addr), v.exp_mem);
        check($sformatf("vec%0d_sram_addr", idx), sram_addr, v.addr);
    endtask

    // ---------------- randomized run against a transaction model ----------------
    typedef enum {K_NONE, K_RD, K_WR} kind_e;

    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_peek(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    // The model tracks only "which access, how many cycles since it was
    // accepted" and derives the expected pins from the latency rules.
    task automatic random_phase(input int n_cycles);
        kind_e       kind = K_NONE;
        int          t = 0;
        logic        p_rd = 1'b0, p_wr = 1'b0;
        logic [15:0] p_addr = '0, p_wdata = '0;
        logic [15:0] m_addr = '0, m_dout = '0, m_rdata = '0;
        logic [5:0]  e_stb;
        for (int n = 0; n < n_cycles; n++) begin
            @(posedge clk); #1;
            if (kind == K_NONE) begin
                if (p_wr) begin
                    kind = K_WR; t = 1; m_addr = p_addr; m_dout = p_wdata;
                    ref_mem[int'(p_addr)] = p_wdata;
                end else if (p_rd) begin
                    kind = K_RD; t = 1; m_addr = p_addr;
                end
            end else begin
                t++;
                if (kind == K_RD && t == W + 2) m_rdata = ref_peek(m_addr);
                if (t == W + 3) kind = K_NONE;
            end
            case (kind)
                K_RD:    e_stb = (t <= W + 1) ? STB_RD : STB_RDY;
                K_WR:    e_stb = (t <= W + 1) ? STB_WR : STB_WREC;
                default: e_stb = STB_IDLE;
            endcase
            check("rand_strobes", stb, e_stb);
            check("rand_rdata", rdata, m_rdata);
            check("rand_sram_addr_dout", {sram_addr, sram_dout}, {m_addr, m_dout});

            p_rd    = ($urandom_range(0, 99) < 40);
            p_wr    = ($urandom_range(0, 99) < 25);
            p_addr  = 16'($urandom_range(0, 255));
            p_wdata = 16'($urandom);
            ram_read = p_rd; ram_write = p_wr; addr = p_addr; wdata = p_wdata;
        end
        ram_read = 1'b0; ram_write = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs [5];

    initial begin
        int          rdy_n, rdy_cyc, first_idle, prev_busy;
        logic [5:0]  z_stb [6];

        vecs[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 3, 4, 3, 0, 0, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 16'h0040, 16'hA5A5, 4, 0, 0, 3, 4, 16'hBEEF, 16'hA5A5};
        vecs[2] = '{1'b1, 1'b1, 16'h0020, 16'h0007, 4, 0, 0, 3, 4, 16'hBEEF, 16'h0007};
        vecs[3] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 3, 4, 3, 0, 0, 16'hA5A5, 16'hA5A5};
        vecs[4] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 3, 4, 3, 0, 0, 16'h0007, 16'h0007};

        // Reset state, applied asynchronously before any clock edge.
        #1;
        check("reset_strobes", stb, STB_IDLE);
        check("reset_rdata", rdata, 16'h0000);
        check("reset_sram_addr", sram_addr, 16'h0000);
        check("reset_sram_dout", sram_dout, 16'h0000);
        check("reset_strobes_w0", stb0, STB_IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        random_phase(600);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Posted write followed by a read the decoder holds until accepted.
        ram_write = 1'b1; addr = 16'h0010; wdata = 16'h1111;
        rdy_cyc = 0; first_idle = 0; prev_busy = 1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin ram_write = 1'b0; ram_read = 1'b1; wdata = 16'h0000; end
            if (!mem_busy && !mem_ready && first_idle == 0) first_idle = c;
            if (mem_busy && prev_busy == 0) ram_read = 1'b0;
            prev_busy = int'(mem_busy);
            if (mem_ready && rdy_cyc == 0) rdy_cyc = c;
        end
        ram_read = 1'b0;
        check("wr_rd_accept_cycle", first_idle, 5);
        check("wr_rd_ready_cycle", rdy_cyc, 9);
        check("wr_rd_rdata", rdata, 16'h1111);

        // Reset in the middle of a read aborts it with no ready pulse.
        ram_read = 1'b1; addr = 16'h1234;
        @(posedge clk); #1;
        ram_read = 1'b0;
        @(posedge clk); #1;
        check("abort_in_rd", stb, STB_RD);
        rst = 1'b1;
        #1;
        check("abort_strobes", stb, STB_IDLE);
        check("abort_rdata", rdata, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        rdy_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (mem_ready) rdy_n++;
        end
        check("abort_no_ready", rdy_n, 0);
        run_vec(vecs[3], 5);

        // Zero-wait build: back-to-back reads, second held until accepted.
        z_stb = '{STB_RD, STB_RDY, STB_IDLE, STB_RD, STB_RDY, STB_IDLE};
        rd0 = 1'b1; addr0 = 16'h0001;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) addr0 = 16'h0002;
            if (c == 4) rd0 = 1'b0;
            check($sformatf("w0_strobes_c%0d", c), stb0, z_stb[c-1]);
            if (c == 2) check("w0_rdata_first", rdata0, init_val(16'h0001));
            if (c == 5) check("w0_rdata_second", rdata0, init_val(16'h0002));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
